// File: rtl/sump_pkg.sv
// Shared SUMP protocol constants and the state encodings used by the
// receive-side command decoder.
package sump_pkg;

  localparam logic [7:0] OP_RESET   = 8'h00;
  localparam logic [7:0] OP_ARM     = 8'h01;
  localparam logic [7:0] OP_ID      = 8'h02;
  localparam logic [7:0] OP_META    = 8'h04;
  localparam logic [7:0] OP_XON     = 8'h11;
  localparam logic [7:0] OP_XOFF    = 8'h13;
  localparam logic [7:0] OP_DIVIDER = 8'h80;
  localparam logic [7:0] OP_CNT     = 8'h81;
  localparam logic [7:0] OP_FLAGS   = 8'h82;

  typedef enum logic [0:0] {
    P_IDLE = 1'b0,
    P_ARG  = 1'b1
  } parser_state_e;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_HOLD = 2'd1,
    R_BUSY = 2'd2
  } req_state_e;

  // Opcodes that ask metadata_sender to transmit something.
  function automatic logic is_meta_op(input logic [7:0] op);
    return (op == OP_ID) || (op == OP_META);
  endfunction

endpackage

// File: rtl/sump_cmd_decoder_if.sv
// Byte stream in, command strobes and metadata request out, between the
// UART/metadata side (master) and the command decoder (slave).
interface sump_cmd_decoder_if;

  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        meta_busy;
  logic        cmd_valid;
  logic        cmd_long;
  logic [7:0]  cmd_opcode;
  logic [31:0] cmd_data;
  logic        sump_reset;
  logic        arm;
  logic        begin_meta_transmit;
  logic        send_id;
  logic        req_dropped;
  logic        cmd_timeout;

  modport master (
    output rx_byte, rx_valid, meta_busy,
    input  cmd_valid, cmd_long, cmd_opcode, cmd_data, sump_reset, arm,
    input  begin_meta_transmit, send_id, req_dropped, cmd_timeout
  );

  modport slave (
    input  rx_byte, rx_valid, meta_busy,
    output cmd_valid, cmd_long, cmd_opcode, cmd_data, sump_reset, arm,
    output begin_meta_transmit, send_id, req_dropped, cmd_timeout
  );

endinterface

// File: rtl/rx_idle_timer.sv
// Counts idle cycles while enabled; expire is high during the CYCLES-th
// consecutive idle cycle, and never in a cycle where clear is asserted.
module rx_idle_timer #(
  parameter int CYCLES = 1_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = $clog2(CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  logic [CW-1:0] cnt_reg;

  assign expire = enable && !clear && (cnt_reg == LAST);

  always_ff @(posedge clock) begin
    if (reset || clear || expire) begin
      cnt_reg <= '0;
    end else if (enable) begin
      cnt_reg <= cnt_reg + CW'(1);
    end
  end

endmodule

// File: rtl/sump_cmd_decoder.sv
// SUMP receive-side command parser: assembles short and long commands,
// pulses capture strobes and drives the held metadata/ID request.
module sump_cmd_decoder
  import sump_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input logic clock,
  input logic reset,
  sump_cmd_decoder_if.slave bus
);

  parser_state_e p_state_reg;
  req_state_e    r_state_reg;
  logic [1:0]    arg_cnt_reg;
  logic [7:0]    long_op_reg;
  logic [23:0]   shadow_reg;

  logic        cmd_valid_reg;
  logic        cmd_long_reg;
  logic [7:0]  cmd_opcode_reg;
  logic [31:0] cmd_data_reg;
  logic        sump_reset_reg;
  logic        arm_reg;
  logic        bmt_reg;
  logic        send_id_reg;
  logic        req_dropped_reg;
  logic        cmd_timeout_reg;

  logic short_done;
  logic long_done;
  logic meta_cmd;
  logic meta_accept;
  logic in_arg;
  logic expire;

  always_comb begin
    in_arg      = (p_state_reg == P_ARG);
    short_done  = bus.rx_valid && !in_arg && !bus.rx_byte[7];
    long_done   = bus.rx_valid && in_arg && (arg_cnt_reg == 2'd3);
    meta_cmd    = short_done && is_meta_op(bus.rx_byte);
    meta_accept = meta_cmd && (r_state_reg == R_IDLE) && !bus.meta_busy;
  end

  rx_idle_timer #(
    .CYCLES(TIMEOUT_CYCLES)
  ) u_idle_timer (
    .clock  (clock),
    .reset  (reset),
    .clear  (bus.rx_valid),
    .enable (in_arg),
    .expire (expire)
  );

  // Parser and command outputs. Argument bytes 0..2 collect in the shadow
  // register so a discarded command never disturbs cmd_data.
  always_ff @(posedge clock) begin
    if (reset) begin
      p_state_reg     <= P_IDLE;
      arg_cnt_reg     <= '0;
      long_op_reg     <= '0;
      shadow_reg      <= '0;
      cmd_valid_reg   <= 1'b0;
      cmd_long_reg    <= 1'b0;
      cmd_opcode_reg  <= '0;
      cmd_data_reg    <= '0;
      sump_reset_reg  <= 1'b0;
      arm_reg         <= 1'b0;
      req_dropped_reg <= 1'b0;
      cmd_timeout_reg <= 1'b0;
    end else begin
      cmd_valid_reg   <= short_done || long_done;
      sump_reset_reg  <= short_done && (bus.rx_byte == OP_RESET);
      arm_reg         <= short_done && (bus.rx_byte == OP_ARM);
      req_dropped_reg <= meta_cmd && !meta_accept;
      cmd_timeout_reg <= expire;

      if (short_done) begin
        cmd_opcode_reg <= bus.rx_byte;
        cmd_data_reg   <= '0;
        cmd_long_reg   <= 1'b0;
      end else if (long_done) begin
        cmd_opcode_reg <= long_op_reg;
        cmd_data_reg   <= {bus.rx_byte, shadow_reg};
        cmd_long_reg   <= 1'b1;
      end

      case (p_state_reg)
        P_IDLE: begin
          if (bus.rx_valid && bus.rx_byte[7]) begin
            long_op_reg <= bus.rx_byte;
            arg_cnt_reg <= '0;
            p_state_reg <= P_ARG;
          end
        end
        P_ARG: begin
          if (bus.rx_valid) begin
            shadow_reg  <= {bus.rx_byte, shadow_reg[23:8]};
            arg_cnt_reg <= arg_cnt_reg + 2'd1;
            if (arg_cnt_reg == 2'd3) begin
              p_state_reg <= P_IDLE;
            end
          end else if (expire) begin
            p_state_reg <= P_IDLE;
          end
        end
        default: p_state_reg <= P_IDLE;
      endcase
    end
  end

  // Request handshake. A reset command cancels a held request one cycle
  // after its strobe, unless the sender has already picked it up.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state_reg <= R_IDLE;
      bmt_reg     <= 1'b0;
      send_id_reg <= 1'b0;
    end else begin
      case (r_state_reg)
        R_IDLE: begin
          if (meta_accept) begin
            send_id_reg <= (bus.rx_byte == OP_ID);
            bmt_reg     <= 1'b1;
            r_state_reg <= R_HOLD;
          end
        end
        R_HOLD: begin
          if (bus.meta_busy) begin
            bmt_reg     <= 1'b0;
            r_state_reg <= R_BUSY;
          end else if (sump_reset_reg) begin
            bmt_reg     <= 1'b0;
            r_state_reg <= R_IDLE;
          end
        end
        R_BUSY: begin
          if (!bus.meta_busy) begin
            r_state_reg <= R_IDLE;
          end
        end
        default: begin
          bmt_reg     <= 1'b0;
          r_state_reg <= R_IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_valid           = cmd_valid_reg;
  assign bus.cmd_long            = cmd_long_reg;
  assign bus.cmd_opcode          = cmd_opcode_reg;
  assign bus.cmd_data            = cmd_data_reg;
  assign bus.sump_reset          = sump_reset_reg;
  assign bus.arm                 = arm_reg;
  assign bus.begin_meta_transmit = bmt_reg;
  assign bus.send_id             = send_id_reg;
  assign bus.req_dropped         = req_dropped_reg;
  assign bus.cmd_timeout         = cmd_timeout_reg;

endmodule

// File: tb/tb_sump_cmd_decoder.sv
// Bench for sump_cmd_decoder: directed scenarios plus random byte traffic,
// checked every cycle against a queue-based protocol model.
module tb_sump_cmd_decoder;

  localparam int TMO = 50;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  sump_cmd_decoder_if bus ();

  sump_cmd_decoder #(
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic        exp_valid, exp_long, exp_reset, exp_arm, exp_bmt, exp_sid, exp_drop, exp_to;
  logic [7:0]  exp_op;
  logic [31:0] exp_data;
  logic [7:0]  q[$];
  int          idle;
  bit          pend, acc;

  always @(posedge clk) begin
    logic [7:0]  op;
    logic [31:0] dat;
    bit done, is_long, old_p, old_a, prev_rst;
    prev_rst = exp_reset;
    exp_valid = 0; exp_reset = 0; exp_arm = 0; exp_drop = 0; exp_to = 0;
    if (rst) begin
      q.delete();
      idle = 0; pend = 0; acc = 0;
      exp_op = 0; exp_data = 0; exp_long = 0; exp_sid = 0; exp_bmt = 0;
    end else begin
      done = 0; is_long = 0; op = 0; dat = 0;
      if (bus.rx_valid) begin
        if (q.size() == 0 && !bus.rx_byte[7]) begin
          done = 1;
          op = bus.rx_byte;
        end else begin
          q.push_back(bus.rx_byte);
          idle = 0;
          if (q.size() == 5) begin
            done = 1; is_long = 1;
            op = q[0];
            dat = {q[4], q[3], q[2], q[1]};
            q.delete();
          end
        end
      end else if (q.size() != 0) begin
        idle++;
        if (idle == TMO) begin
          q.delete();
          exp_to = 1;
        end
      end
      if (done) begin
        exp_valid = 1; exp_op = op; exp_data = dat; exp_long = is_long;
      end
      if (done && !is_long) begin
        exp_reset = (op == 8'h00);
        exp_arm   = (op == 8'h01);
      end
      old_p = pend; old_a = acc;
      if (pend) begin
        if (bus.meta_busy) begin pend = 0; acc = 1; end
        else if (prev_rst) pend = 0;
      end else if (acc) begin
        if (!bus.meta_busy) acc = 0;
      end
      if (done && !is_long && (op == 8'h02 || op == 8'h04)) begin
        if (old_p || old_a || bus.meta_busy) exp_drop = 1;
        else begin
          pend = 1;
          exp_sid = (op == 8'h02);
        end
      end
      exp_bmt = pend;
    end
  end

  // ---------------- per-cycle compare ----------------
  int n_valid, n_reset, n_arm, n_drop, n_to;

  always @(posedge clk) begin
    #1;
    chk("cmd_valid",   32'(bus.cmd_valid),           32'(exp_valid));
    chk("cmd_long",    32'(bus.cmd_long),            32'(exp_long));
    chk("cmd_opcode",  32'(bus.cmd_opcode),          32'(exp_op));
    chk("cmd_data",    bus.cmd_data,                 exp_data);
    chk("sump_reset",  32'(bus.sump_reset),          32'(exp_reset));
    chk("arm",         32'(bus.arm),                 32'(exp_arm));
    chk("begin_meta",  32'(bus.begin_meta_transmit), 32'(exp_bmt));
    chk("send_id",     32'(bus.send_id),             32'(exp_sid));
    chk("req_dropped", 32'(bus.req_dropped),         32'(exp_drop));
    chk("cmd_timeout", 32'(bus.cmd_timeout),         32'(exp_to));
    if (bus.cmd_valid === 1'b1)   n_valid++;
    if (bus.sump_reset === 1'b1)  n_reset++;
    if (bus.arm === 1'b1)         n_arm++;
    if (bus.req_dropped === 1'b1) n_drop++;
    if (bus.cmd_timeout === 1'b1) n_to++;
  end

  // ---------------- stimulus ----------------
  logic [7:0] short_ops [0:5] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h11, 8'h13};
  logic [7:0] long_ops  [0:3] = '{8'h80, 8'h81, 8'h82, 8'hC0};

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    bus.rx_byte  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  function automatic logic [7:0] pick();
    int r;
    r = $urandom_range(0, 9);
    if (r < 5)      return short_ops[$urandom_range(0, 5)];
    else if (r < 7) return long_ops[$urandom_range(0, 3)];
    else            return 8'($urandom_range(0, 255));
  endfunction

  initial begin
    int s_valid, s_reset, s_to, s_drop;
    total = 0; bad = 0;
    n_valid = 0; n_reset = 0; n_arm = 0; n_drop = 0; n_to = 0;
    rst = 1'b1;
    bus.rx_valid = 1'b0; bus.rx_byte = 8'h00; bus.meta_busy = 1'b0;
    repeat (3) tick();
    chk("rst_opcode", 32'(bus.cmd_opcode), 32'h0);
    chk("rst_valid",  32'(bus.cmd_valid),  32'h0);
    chk("rst_bmt",    32'(bus.begin_meta_transmit), 32'h0);
    rst = 1'b0;
    tick();

    // five back-to-back resets
    s_valid = n_valid; s_reset = n_reset;
    repeat (5) send(8'h00);
    repeat (2) tick();
    chk("s1_valid_cnt", 32'(n_valid - s_valid), 32'd5);
    chk("s1_reset_cnt", 32'(n_reset - s_reset), 32'd5);
    chk("s1_long", 32'(bus.cmd_long), 32'h0);
    chk("s1_data", bus.cmd_data, 32'h0);

    // long command, back-to-back bytes
    s_valid = n_valid;
    send(8'h80); send(8'h10); send(8'h27); send(8'h00);
    chk("s2_early_valid", 32'(n_valid - s_valid), 32'd0);
    send(8'h00);
    chk("s2_valid",  32'(bus.cmd_valid),  32'h1);
    chk("s2_opcode", 32'(bus.cmd_opcode), 32'h80);
    chk("s2_data",   bus.cmd_data,        32'h0000_2710);
    chk("s2_long",   32'(bus.cmd_long),   32'h1);
    tick();
    chk("s2_valid_cnt", 32'(n_valid - s_valid), 32'd1);

    // ID request held 20 cycles, then accepted; 0x04 while busy is dropped
    send(8'h02);
    chk("s3_bmt_rise", 32'(bus.begin_meta_transmit), 32'h1);
    chk("s3_sid",      32'(bus.send_id), 32'h1);
    repeat (19) tick();
    chk("s3_bmt_held", 32'(bus.begin_meta_transmit), 32'h1);
    bus.meta_busy = 1'b1;
    tick();
    chk("s3_bmt_fall", 32'(bus.begin_meta_transmit), 32'h0);
    send(8'h04);
    chk("s3_dropped", 32'(bus.req_dropped), 32'h1);
    chk("s3_no_req",  32'(bus.begin_meta_transmit), 32'h0);
    bus.meta_busy = 1'b0;
    repeat (2) tick();
    send(8'h04);
    chk("s3_meta_req", 32'(bus.begin_meta_transmit), 32'h1);
    chk("s3_meta_sid", 32'(bus.send_id), 32'h0);
    repeat (3) tick();
    bus.meta_busy = 1'b1;
    repeat (4) tick();
    bus.meta_busy = 1'b0;
    repeat (2) tick();

    // partial long command times out after TMO idle cycles
    send(8'hC0); send(8'hAA);
    s_to = n_to; s_valid = n_valid;
    repeat (TMO - 1) tick();
    chk("s4_no_early_to", 32'(n_to - s_to), 32'd0);
    tick();
    chk("s4_timeout", 32'(bus.cmd_timeout), 32'h1);
    chk("s4_no_valid", 32'(n_valid - s_valid), 32'd0);
    chk("s4_opcode_kept", 32'(bus.cmd_opcode), 32'h04);
    chk("s4_data_kept", bus.cmd_data, 32'h0);
    send(8'h01);
    chk("s4_arm", 32'(bus.arm), 32'h1);

    // reset command cancels a held request
    tick();
    send(8'h04);
    chk("s5_req", 32'(bus.begin_meta_transmit), 32'h1);
    tick();
    send(8'h00);
    chk("s5_sump_reset", 32'(bus.sump_reset), 32'h1);
    chk("s5_still_held", 32'(bus.begin_meta_transmit), 32'h1);
    tick();
    chk("s5_cancelled", 32'(bus.begin_meta_transmit), 32'h0);

    // reset in the middle of a long command
    send(8'h81); send(8'h11); send(8'h22);
    rst = 1'b1;
    tick();
    chk("s6_opcode", 32'(bus.cmd_opcode), 32'h0);
    chk("s6_data",   bus.cmd_data, 32'h0);
    chk("s6_long",   32'(bus.cmd_long), 32'h0);
    rst = 1'b0;
    s_valid = n_valid;
    send(8'h01);
    chk("s6_arm",    32'(bus.arm), 32'h1);
    chk("s6_op",     32'(bus.cmd_opcode), 32'h01);
    repeat (3) tick();
    chk("s6_valid_cnt", 32'(n_valid - s_valid), 32'd1);

    // random traffic
    s_drop = n_drop; s_to = n_to;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 599) == 0) begin
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
      end else if ($urandom_range(0, 149) == 0) begin
        repeat (TMO + 5) tick();
      end else begin
        if ($urandom_range(0, 7) == 0) bus.meta_busy = ~bus.meta_busy;
        if ($urandom_range(0, 9) < 4) begin
          bus.rx_byte  = pick();
          bus.rx_valid = 1'b1;
        end
        tick();
        bus.rx_valid = 1'b0;
      end
    end
    repeat (3) tick();
    $display("random phase: drops=%0d timeouts=%0d", n_drop - s_drop, n_to - s_to);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
